proto_monitor: RTL and testbench

Synthesizable, parametrised multi-channel protocol monitor for the rt/start/rdy/endd/stop/er transaction interface. It enforces the interface's rules in hardware at run time, per channel:
- reset-window quiet state
- bounded start-to-rdy latency
- rdy pulse around termination
- bounded er runs
- endd/start exclusion

Violations are recorded in sticky flags, a saturating counter, a first-violation capture register and an interrupt. It sits beside the datapath on the shared clock, observes only, and never drives the monitored interface.

---
 rtl/proto_monitor_pkg.sv | 26 ++
 rtl/proto_monitor_ch.sv | 105 ++++++++++
 rtl/proto_monitor.sv | 133 +++++++++++++
 tb/tb_proto_monitor.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proto_monitor_pkg.sv
// rtl/proto_monitor_pkg.sv - shared types and constants for the protocol monitor
package proto_monitor_pkg;

    localparam int RULE_W    = 3;
    localparam int NUM_RULES = 6;

    typedef enum logic [RULE_W-1:0] {
        R_INIT        = 3'd0,
        R_TERM_RDY    = 3'd1,
        R_TERM_DROP   = 3'd2,
        R_ER_RUN      = 3'd3,
        R_RDY_TIMEOUT = 3'd4,
        R_END_START   = 3'd5
    } rule_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } ch_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/proto_monitor_ch.sv
// rtl/proto_monitor_ch.sv - per-channel rule checker: FSM, start-to-rdy timer, er run counter
module proto_monitor_ch
    import proto_monitor_pkg::*;
#(
    parameter int MAX_ER_RUN  = 3,
    parameter int RDY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_window,
    input  logic                 rt,
    input  logic                 start,
    input  logic                 rdy,
    input  logic                 endd,
    input  logic                 stop,
    input  logic                 er,
    output logic [NUM_RULES-1:0] ev
);

    localparam int TMR_W = $clog2(RDY_TIMEOUT + 1);
    localparam int ER_W  = $clog2(MAX_ER_RUN + 2);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(RDY_TIMEOUT);
    localparam logic [ER_W-1:0]  ER_LIMIT  = ER_W'(MAX_ER_RUN);
    localparam logic [ER_W-1:0]  ER_SAT    = ER_W'(MAX_ER_RUN + 1);

    ch_state_e            state;
    logic [TMR_W-1:0]     timer;
    logic [ER_W-1:0]      er_cnt;
    logic                 term;
    logic                 timed_out;
    logic [NUM_RULES-1:0] ev_nxt;

    assign term      = endd | stop | er;
    assign timed_out = (state == ST_WAIT) && !rdy && (timer == TMR_LIMIT);

    // Every rule is evaluated in parallel; only rule 0 is live inside the reset window.
    always_comb begin
        ev_nxt                = '0;
        ev_nxt[R_INIT]        = in_window & (~rt | rdy | start | endd);
        ev_nxt[R_TERM_RDY]    = ~in_window & term & ~rdy;
        ev_nxt[R_TERM_DROP]   = ~in_window & (state == ST_DROP) & rdy;
        ev_nxt[R_ER_RUN]      = ~in_window & er & (er_cnt == ER_LIMIT);
        ev_nxt[R_RDY_TIMEOUT] = ~in_window & timed_out;
        ev_nxt[R_END_START]   = ~in_window & endd & start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            timer  <= '0;
            er_cnt <= '0;
            ev     <= '0;
        end else begin
            ev <= ev_nxt;
            if (in_window) begin
                state  <= ST_IDLE;
                timer  <= '0;
                er_cnt <= '0;
            end else begin
                if (!er)
                    er_cnt <= '0;
                else if (er_cnt != ER_SAT)
                    er_cnt <= er_cnt + 1'b1;

                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_WAIT;
                            timer <= TMR_W'(1);
                        end else if (term && rdy) begin
                            state <= ST_DROP;
                        end
                    end
                    ST_WAIT: begin
                        // Further starts while waiting do not rearm the timer.
                        if (rdy) begin
                            state <= term ? ST_DROP : ST_IDLE;
                            timer <= '0;
                        end else if (timer == TMR_LIMIT) begin
                            state <= ST_IDLE;
                            timer <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    ST_DROP: begin
                        if (start) begin
                            state <= ST_WAIT;
                            timer <= TMR_W'(1);
                        end else if (term) begin
                            state <= ST_DROP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/proto_monitor.sv
// rtl/proto_monitor.sv - multi-channel interface rule monitor with sticky flags, counter and capture
module proto_monitor
    import proto_monitor_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int INIT_CYCLES = 4,
    parameter int MAX_ER_RUN  = 3,
    parameter int RDY_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_CH-1:0]                    ch_rt,
    input  logic [N_CH-1:0]                    ch_start,
    input  logic [N_CH-1:0]                    ch_rdy,
    input  logic [N_CH-1:0]                    ch_endd,
    input  logic [N_CH-1:0]                    ch_stop,
    input  logic [N_CH-1:0]                    ch_er,
    input  logic                               clr,
    output logic [N_CH*NUM_RULES-1:0]          viol_sticky,
    output logic [CNT_W-1:0]                   viol_cnt,
    output logic                               first_vld,
    output logic [ch_width(N_CH)-1:0]          first_ch,
    output logic [RULE_W-1:0]                  first_rule,
    output logic                               irq,
    output logic                               init_done
);

    localparam int CH_W  = ch_width(N_CH);
    localparam int EV_N  = N_CH * NUM_RULES;
    localparam int WIN_W = $clog2(INIT_CYCLES + 1);
    localparam int POP_W = $clog2(EV_N + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIN_W-1:0]  win_cnt;
    logic [EV_N-1:0]   ev_all;
    logic [POP_W-1:0]  pop;
    logic [EV_N-1:0]   sticky_nxt;
    logic [CNT_W-1:0]  cnt_base;
    logic [SUM_W-1:0]  cnt_sum;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              vld_base;
    logic              hit;
    logic [CH_W-1:0]   hit_ch;
    logic [RULE_W-1:0] hit_rule;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt   <= '0;
            init_done <= 1'b0;
        end else if (!init_done) begin
            if (win_cnt == WIN_W'(INIT_CYCLES - 1))
                init_done <= 1'b1;
            else
                win_cnt <= win_cnt + 1'b1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        proto_monitor_ch #(
            .MAX_ER_RUN  (MAX_ER_RUN),
            .RDY_TIMEOUT (RDY_TIMEOUT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_window (~init_done),
            .rt        (ch_rt[c]),
            .start     (ch_start[c]),
            .rdy       (ch_rdy[c]),
            .endd      (ch_endd[c]),
            .stop      (ch_stop[c]),
            .er        (ch_er[c]),
            .ev        (ev_all[c*NUM_RULES +: NUM_RULES])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < EV_N; i++)
            pop = pop + POP_W'(ev_all[i]);
    end

    // clr wipes the old state first so an event arriving with it is still recorded.
    always_comb begin
        sticky_nxt = (clr ? '0 : viol_sticky) | ev_all;
        cnt_base   = clr ? '0 : viol_cnt;
        vld_base   = clr ? 1'b0 : first_vld;
        cnt_sum    = SUM_W'(cnt_base) + SUM_W'(pop);
        cnt_nxt    = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    // Scan from the top down so the lowest channel, then lowest rule, wins.
    always_comb begin
        hit      = 1'b0;
        hit_ch   = '0;
        hit_rule = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            for (int r = NUM_RULES - 1; r >= 0; r--) begin
                if (ev_all[c*NUM_RULES + r]) begin
                    hit      = 1'b1;
                    hit_ch   = CH_W'(c);
                    hit_rule = RULE_W'(r);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_sticky <= '0;
            viol_cnt    <= '0;
            first_vld   <= 1'b0;
            first_ch    <= '0;
            first_rule  <= '0;
            irq         <= 1'b0;
        end else begin
            viol_sticky <= sticky_nxt;
            viol_cnt    <= cnt_nxt;
            irq         <= |sticky_nxt;
            if (!vld_base && hit) begin
                first_vld  <= 1'b1;
                first_ch   <= hit_ch;
                first_rule <= hit_rule;
            end else if (clr) begin
                first_vld  <= 1'b0;
                first_ch   <= '0;
                first_rule <= '0;
            end
        end
    end

endmodule

// File: tb/tb_proto_monitor.sv
// tb/tb_proto_monitor.sv - scenario bench for proto_monitor with expected-result queue
module tb_proto_monitor;
    import proto_monitor_pkg::*;

    localparam int N_CH = 4;
    localparam int W    = N_CH * NUM_RULES;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] ch_rt, ch_start, ch_rdy, ch_endd, ch_stop, ch_er;
    logic            clr, clr2;

    logic [W-1:0]    viol_sticky, viol_sticky2;
    logic [7:0]      viol_cnt;
    logic [1:0]      viol_cnt2;
    logic            first_vld, first_vld2;
    logic [1:0]      first_ch, first_ch2;
    logic [2:0]      first_rule, first_rule2;
    logic            irq, irq2, init_done, init_done2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] sticky;
        logic [7:0]   cnt;
    } exp_t;
    exp_t sb[$];

    proto_monitor #(.N_CH(N_CH), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .ch_rt(ch_rt), .ch_start(ch_start), .ch_rdy(ch_rdy),
        .ch_endd(ch_endd), .ch_stop(ch_stop), .ch_er(ch_er), .clr(clr),
        .viol_sticky(viol_sticky), .viol_cnt(viol_cnt), .first_vld(first_vld),
        .first_ch(first_ch), .first_rule(first_rule), .irq(irq), .init_done(init_done)
    );

    proto_monitor #(.N_CH(N_CH), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ch_rt(ch_rt), .ch_start(ch_start), .ch_rdy(ch_rdy),
        .ch_endd(ch_endd), .ch_stop(ch_stop), .ch_er(ch_er), .clr(clr2),
        .viol_sticky(viol_sticky2), .viol_cnt(viol_cnt2), .first_vld(first_vld2),
        .first_ch(first_ch2), .first_rule(first_rule2), .irq(irq2), .init_done(init_done2)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] onehot(input int ch, input int rule);
        logic [W-1:0] r;
        r = '0;
        r[ch*NUM_RULES + rule] = 1'b1;
        return r;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ch_rt = '1; ch_start = '0; ch_rdy = '0; ch_endd = '0; ch_stop = '0; ch_er = '0;
        clr = 1'b0; clr2 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic clear_flags();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        idle_inputs();
        tick(2);
        n_checks++;
        if (viol_sticky !== '0 || viol_cnt !== 8'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: sticky=%h cnt=%0d irq=%b, expected 0", viol_sticky, viol_cnt, irq);
        end
        n_checks++;
        if (first_vld !== 1'b0 || first_ch !== 2'd0 || first_rule !== 3'd0 || init_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_capture: vld=%b ch=%0d rule=%0d init_done=%b, expected 0", first_vld, first_ch, first_rule, init_done);
        end
        rst_n = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (n !== 4) begin
            n_fail++; $display("FAIL reset_window_len: init_done after %0d edges, expected 4", n);
        end
    endtask

    task automatic test_init();
        exp_t e;
        do_reset();
        tick();
        ch_rt[0] = 1'b0;
        e.sticky = onehot(0, 0); e.cnt = 8'd1; sb.push_back(e);
        tick();
        ch_rt[0] = 1'b1;
        tick();
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt) begin
            n_fail++; $display("FAIL init_event: sticky=%h cnt=%0d, expected %h %0d", viol_sticky, viol_cnt, e.sticky, e.cnt);
        end
        n_checks++;
        if (first_vld !== 1'b1 || first_ch !== 2'd0 || first_rule !== 3'd0 || irq !== 1'b1) begin
            n_fail++; $display("FAIL init_capture: vld=%b ch=%0d rule=%0d irq=%b, expected 1 0 0 1", first_vld, first_ch, first_rule, irq);
        end
        tick();
        e.sticky = onehot(0, 0); e.cnt = 8'd1; sb.push_back(e);
        ch_rt[0] = 1'b0;
        tick();
        ch_rt[0] = 1'b1;
        tick(2);
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt || init_done !== 1'b1) begin
            n_fail++; $display("FAIL init_after_window: sticky=%h cnt=%0d done=%b, expected %h %0d 1", viol_sticky, viol_cnt, init_done, e.sticky, e.cnt);
        end
        clear_flags();
        n_checks++;
        if (viol_sticky !== '0 || viol_cnt !== 8'd0 || first_vld !== 1'b0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL clr: sticky=%h cnt=%0d vld=%b irq=%b, expected all 0", viol_sticky, viol_cnt, first_vld, irq);
        end
    endtask

    task automatic test_rdy_ok();
        exp_t e;
        e.sticky = '0; e.cnt = 8'd0; sb.push_back(e);
        ch_start[1] = 1'b1;
        tick();
        ch_start[1] = 1'b0;
        tick(4);
        ch_rdy[1] = 1'b1;
        tick();
        ch_rdy[1] = 1'b0;
        tick(20);
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt) begin
            n_fail++; $display("FAIL rdy_in_time: sticky=%h cnt=%0d, expected %h %0d", viol_sticky, viol_cnt, e.sticky, e.cnt);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int n;
        e.sticky = onehot(1, 4); e.cnt = 8'd1; sb.push_back(e);
        ch_start[1] = 1'b1;
        tick();
        ch_start[1] = 1'b0;
        n = 0;
        while (viol_sticky[1*NUM_RULES + 4] !== 1'b1 && n < 40) begin tick(); n++; end
        n_checks++;
        if (n !== 17) begin
            n_fail++; $display("FAIL timeout_latency: flag after %0d edges, expected 17", n);
        end
        tick(2);
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt || first_rule !== 3'd4 || first_ch !== 2'd1) begin
            n_fail++; $display("FAIL timeout_event: sticky=%h cnt=%0d ch=%0d rule=%0d, expected %h %0d 1 4", viol_sticky, viol_cnt, first_ch, first_rule, e.sticky, e.cnt);
        end
        clear_flags();
    endtask

    task automatic test_er_run();
        exp_t e;
        e.sticky = onehot(2, 2); e.cnt = 8'd2; sb.push_back(e);
        ch_rdy[2] = 1'b1; ch_er[2] = 1'b1;
        tick(3);
        ch_rdy[2] = 1'b0; ch_er[2] = 1'b0;
        tick(3);
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt) begin
            n_fail++; $display("FAIL er_short: sticky=%h cnt=%0d, expected %h %0d", viol_sticky, viol_cnt, e.sticky, e.cnt);
        end
        clear_flags();
        e.sticky = onehot(2, 2) | onehot(2, 3); e.cnt = 8'd10; sb.push_back(e);
        ch_rdy[2] = 1'b1; ch_er[2] = 1'b1;
        tick(10);
        ch_rdy[2] = 1'b0; ch_er[2] = 1'b0;
        tick(3);
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt) begin
            n_fail++; $display("FAIL er_long: sticky=%h cnt=%0d, expected %h %0d", viol_sticky, viol_cnt, e.sticky, e.cnt);
        end
        n_checks++;
        if (first_ch !== 2'd2 || first_rule !== 3'd2) begin
            n_fail++; $display("FAIL er_capture: ch=%0d rule=%0d, expected 2 2", first_ch, first_rule);
        end
        clear_flags();
    endtask

    task automatic test_term();
        exp_t e;
        e.sticky = onehot(3, 2); e.cnt = 8'd1; sb.push_back(e);
        ch_endd[3] = 1'b1; ch_rdy[3] = 1'b1;
        tick();
        ch_endd[3] = 1'b0;
        tick();
        ch_rdy[3] = 1'b0;
        tick(2);
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt) begin
            n_fail++; $display("FAIL term_drop: sticky=%h cnt=%0d, expected %h %0d", viol_sticky, viol_cnt, e.sticky, e.cnt);
        end
        clear_flags();
        e.sticky = onehot(3, 1); e.cnt = 8'd1; sb.push_back(e);
        ch_endd[3] = 1'b1;
        tick();
        ch_endd[3] = 1'b0;
        tick(2);
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt) begin
            n_fail++; $display("FAIL term_rdy: sticky=%h cnt=%0d, expected %h %0d", viol_sticky, viol_cnt, e.sticky, e.cnt);
        end
        clear_flags();
        e.sticky = onehot(3, 5); e.cnt = 8'd1; sb.push_back(e);
        ch_endd[3] = 1'b1; ch_start[3] = 1'b1; ch_rdy[3] = 1'b1;
        tick();
        ch_endd[3] = 1'b0; ch_start[3] = 1'b0;
        tick();
        ch_rdy[3] = 1'b0;
        tick(2);
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt || first_rule !== 3'd5) begin
            n_fail++; $display("FAIL end_start: sticky=%h cnt=%0d rule=%0d, expected %h %0d 5", viol_sticky, viol_cnt, first_rule, e.sticky, e.cnt);
        end
        clear_flags();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        e.sticky = onehot(0, 1) | onehot(2, 1); e.cnt = 8'd2; sb.push_back(e);
        ch_endd[0] = 1'b1; ch_endd[2] = 1'b1;
        tick();
        ch_endd[0] = 1'b0; ch_endd[2] = 1'b0;
        tick(2);
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt || first_ch !== 2'd0 || first_rule !== 3'd1) begin
            n_fail++; $display("FAIL same_cycle: sticky=%h cnt=%0d ch=%0d rule=%0d, expected %h %0d 0 1", viol_sticky, viol_cnt, first_ch, first_rule, e.sticky, e.cnt);
        end
        e.sticky = onehot(1, 1); e.cnt = 8'd1; sb.push_back(e);
        ch_endd[1] = 1'b1;
        tick();
        ch_endd[1] = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (viol_sticky !== e.sticky || viol_cnt !== e.cnt || first_vld !== 1'b1 || first_ch !== 2'd1) begin
            n_fail++; $display("FAIL clr_with_event: sticky=%h cnt=%0d vld=%b ch=%0d, expected %h %0d 1 1", viol_sticky, viol_cnt, first_vld, first_ch, e.sticky, e.cnt);
        end
        clear_flags();
    endtask

    task automatic test_saturate();
        do_reset();
        tick(4);
        ch_endd[0] = 1'b1;
        tick(5);
        ch_endd[0] = 1'b0;
        tick(2);
        n_checks++;
        if (viol_cnt !== 8'd5) begin
            n_fail++; $display("FAIL count_wide: cnt=%0d, expected 5", viol_cnt);
        end
        n_checks++;
        if (viol_cnt2 !== 2'd3) begin
            n_fail++; $display("FAIL count_saturate: cnt=%0d, expected 3", viol_cnt2);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        ch_start[1] = 1'b1;
        tick();
        ch_start[1] = 1'b0;
        tick(3);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (viol_sticky !== '0 || viol_cnt !== 8'd0 || viol_cnt2 !== 2'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL midreset_flags: sticky=%h cnt=%0d cnt2=%0d irq=%b, expected 0", viol_sticky, viol_cnt, viol_cnt2, irq);
        end
        n_checks++;
        if (first_vld !== 1'b0 || first_ch !== 2'd0 || first_rule !== 3'd0 || init_done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_capture: vld=%b ch=%0d rule=%0d done=%b, expected 0", first_vld, first_ch, first_rule, init_done);
        end
        tick();
        rst_n = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 20) begin tick(); n++; end
        n_checks++;
        if (n !== 4) begin
            n_fail++; $display("FAIL midreset_window: init_done after %0d edges, expected 4", n);
        end
        tick(25);
        n_checks++;
        if (viol_cnt !== 8'd0 || viol_sticky !== '0) begin
            n_fail++; $display("FAIL midreset_fsm: cnt=%0d sticky=%h, expected 0 (stale wait)", viol_cnt, viol_sticky);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_init();
        test_rdy_ok();
        test_timeout();
        test_er_run();
        test_term();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
